// File: rtl/shared_mem_arbiter.sv
// Two-requester arbiter/sequencer for the CPU's single-port shared memory.
// Each access is ISSUE (command on the bus) followed by COMPLETE (done, read data).
module shared_mem_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_lock,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              dbg_starve
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT) + 1;
  localparam logic [WAIT_W-1:0] LIMIT_W = WAIT_W'(STARVE_LIMIT);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] COMPLETE = 2'd2;

  // Requester 0 is the CPU, requester 1 is the debug port.
  logic [1:0]                   eligible;
  logic [1:0]                   we_vec;
  logic [1:0][ADDR_W-1:0]       addr_vec;
  logic [1:0][DATA_W-1:0]       wdata_vec;
  logic [1:0][DATA_W-1:0]       rdata_vec;

  logic [1:0]        state_reg, state_next;
  logic              owner_reg, owner_next;
  logic              other;
  logic              start;

  logic              mem_en_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [1:0]        gnt_reg;
  logic [1:0]        done_reg;

  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              starve_reg;
  logic              grant_dbg;

  assign eligible  = {dbg_req & ~cpu_lock, cpu_req};
  assign we_vec    = {dbg_we, cpu_we};
  assign addr_vec  = {dbg_addr, cpu_addr};
  assign wdata_vec = {dbg_wdata, cpu_wdata};
  assign other     = ~owner_reg;

  // start marks the edge at which a new command is latched onto the bus.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    start      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (eligible[0]) begin
          state_next = ISSUE;
          owner_next = 1'b0;
          start      = 1'b1;
        end else if (eligible[1]) begin
          state_next = ISSUE;
          owner_next = 1'b1;
          start      = 1'b1;
        end
      end
      ISSUE: begin
        state_next = COMPLETE;
      end
      COMPLETE: begin
        // The owner's req is still high here, so only the other side can follow.
        if (eligible[other]) begin
          state_next = ISSUE;
          owner_next = other;
          start      = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      gnt_reg       <= 2'b00;
      done_reg      <= 2'b00;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      mem_en_reg <= start;
      gnt_reg    <= start ? (owner_next ? 2'b10 : 2'b01) : 2'b00;
      done_reg   <= (state_reg == ISSUE) ? (owner_reg ? 2'b10 : 2'b01) : 2'b00;
      if (start) begin
        mem_we_reg    <= we_vec[owner_next];
        mem_addr_reg  <= addr_vec[owner_next];
        mem_wdata_reg <= wdata_vec[owner_next];
      end
    end
  end

  // Per-requester read-data hold register with same-cycle bypass in COMPLETE.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic [DATA_W-1:0] hold_reg;
    logic              bypass;

    assign bypass = done_reg[gi] & ~mem_we_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        hold_reg <= '0;
      end else if (bypass) begin
        hold_reg <= mem_rdata;
      end
    end

    assign rdata_vec[gi] = bypass ? mem_rdata : hold_reg;
  end

  // Cleared on the edge that raises dbg_gnt, so the flag is already low in the grant cycle.
  assign grant_dbg = start & owner_next;

  always_comb begin
    wait_next = wait_reg;
    if (grant_dbg) begin
      wait_next = '0;
    end else if (dbg_req && !gnt_reg[1] && (wait_reg != '1)) begin
      wait_next = wait_reg + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_reg   <= '0;
      starve_reg <= 1'b0;
    end else begin
      wait_reg <= wait_next;
      if (grant_dbg) begin
        starve_reg <= 1'b0;
      end else if (wait_next >= LIMIT_W) begin
        starve_reg <= 1'b1;
      end
    end
  end

  assign cpu_gnt    = gnt_reg[0];
  assign dbg_gnt    = gnt_reg[1];
  assign cpu_done   = done_reg[0];
  assign dbg_done   = done_reg[1];
  assign cpu_rdata  = rdata_vec[0];
  assign dbg_rdata  = rdata_vec[1];
  assign mem_en     = mem_en_reg;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign owner      = owner_reg;
  assign dbg_starve = starve_reg;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: access-schedule model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_shared_mem_arbiter;

  localparam int LIMIT    = 8;
  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_lock;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt, cpu_done;
  logic [31:0] cpu_rdata;
  logic        dbg_req, dbg_we;
  logic [8:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_done;
  logic [31:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        owner, dbg_starve;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit cpu_auto = 1'b0;

  always #5 clk = ~clk;

  shared_mem_arbiter #(.ADDR_W(9), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_lock(cpu_lock), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .dbg_starve(dbg_starve)
  );

  // Synchronous single-port RAM behind the arbiter.
  logic [31:0] ram [0:511];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model: a schedule of accesses ----------------
  logic [31:0] model_mem [0:511];
  bit          started = 1'b0;
  int          last_gnt = -10;
  int          last_who = 0;
  bit          last_we = 1'b0;
  logic [8:0]  last_addr = 9'h0;
  logic [31:0] last_wdata = 32'h0;
  logic [31:0] last_rval = 32'h0;
  logic [31:0] hold [2];
  int          wait_cnt = 0;
  bit          starve = 1'b0;
  logic [1:0]  exp_gnt = 2'b00, exp_done = 2'b00;
  logic [31:0] exp_rdata [2];

  initial begin
    hold[0] = 32'h0; hold[1] = 32'h0;
    exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
  end

  always @(posedge clk) begin
    int  prev;
    int  who_new;
    bit  dbg_gnt_prev;
    cyc++;
    prev = cyc - 1;
    if (rst) begin
      started    = 1'b1;
      last_gnt   = -10;
      last_who   = 0;
      last_we    = 1'b0;
      last_addr  = 9'h0;
      last_wdata = 32'h0;
      hold[0]    = 32'h0;
      hold[1]    = 32'h0;
      wait_cnt   = 0;
      starve     = 1'b0;
    end else begin
      if (last_gnt + 1 == prev && !last_we) hold[last_who] = last_rval;
      dbg_gnt_prev = (last_gnt == prev) && (last_who == 1);
      who_new = -1;
      if (last_gnt == prev) begin
        who_new = -1;
      end else if (last_gnt + 1 == prev) begin
        if (last_who == 0 && dbg_req && !cpu_lock) who_new = 1;
        else if (last_who == 1 && cpu_req)         who_new = 0;
      end else begin
        if (cpu_req)                    who_new = 0;
        else if (dbg_req && !cpu_lock)  who_new = 1;
      end
      if (who_new >= 0) begin
        last_gnt   = cyc;
        last_who   = who_new;
        last_we    = (who_new == 0) ? cpu_we : dbg_we;
        last_addr  = (who_new == 0) ? cpu_addr : dbg_addr;
        last_wdata = (who_new == 0) ? cpu_wdata : dbg_wdata;
        if (last_we) model_mem[last_addr] = last_wdata;
        else         last_rval = model_mem[last_addr];
      end
      if (who_new == 1) begin
        wait_cnt = 0;
        starve   = 1'b0;
      end else begin
        if (dbg_req && !dbg_gnt_prev && wait_cnt < WAIT_MAX) wait_cnt++;
        if (wait_cnt >= LIMIT) starve = 1'b1;
      end
    end
    for (int w = 0; w < 2; w++) begin
      exp_gnt[w]   = (last_gnt == cyc) && (last_who == w);
      exp_done[w]  = (last_gnt + 1 == cyc) && (last_who == w);
      exp_rdata[w] = (exp_done[w] && !last_we) ? last_rval : hold[w];
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk1("m_cpu_gnt", cpu_gnt, exp_gnt[0]);
      chk1("m_dbg_gnt", dbg_gnt, exp_gnt[1]);
      chk1("m_cpu_done", cpu_done, exp_done[0]);
      chk1("m_dbg_done", dbg_done, exp_done[1]);
      chk1("m_mem_en", mem_en, exp_gnt[0] | exp_gnt[1]);
      chk1("m_mem_we", mem_we, last_we);
      chk32("m_mem_addr", {23'h0, mem_addr}, {23'h0, last_addr});
      chk32("m_mem_wdata", mem_wdata, last_wdata);
      chk1("m_owner", owner, last_who[0]);
      chk32("m_cpu_rdata", cpu_rdata, exp_rdata[0]);
      chk32("m_dbg_rdata", dbg_rdata, exp_rdata[1]);
      chk1("m_dbg_starve", dbg_starve, starve);
    end
  end

  // ---------------- stimulus ----------------
  // One clock step; inputs change 2 units after the edge. A requester drops
  // req in the cycle after its done; in auto mode the CPU re-requests next cycle.
  task automatic cycle();
    logic cd, dd;
    cd = cpu_done;
    dd = dbg_done;
    @(posedge clk);
    #2;
    if (cd === 1'b1)  cpu_req = 1'b0;
    else if (cpu_auto) cpu_req = 1'b1;
    if (dd === 1'b1)  dbg_req = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_cpu_gnt"}, cpu_gnt, 1'b0);
    chk1({tag, "_cpu_done"}, cpu_done, 1'b0);
    chk1({tag, "_dbg_gnt"}, dbg_gnt, 1'b0);
    chk1({tag, "_dbg_done"}, dbg_done, 1'b0);
    chk1({tag, "_mem_en"}, mem_en, 1'b0);
    chk1({tag, "_mem_we"}, mem_we, 1'b0);
    chk32({tag, "_mem_addr"}, {23'h0, mem_addr}, 32'h0);
    chk32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk32({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    chk32({tag, "_dbg_rdata"}, dbg_rdata, 32'h0);
    chk1({tag, "_owner"}, owner, 1'b0);
    chk1({tag, "_dbg_starve"}, dbg_starve, 1'b0);
  endtask

  initial begin
    bit got;
    int seen;
    for (int i = 0; i < 512; i++) begin
      ram[i] = 32'h0;
      model_mem[i] = 32'h0;
    end
    ram[9'h005] = 32'h8C010004; model_mem[9'h005] = 32'h8C010004;
    ram[9'h020] = 32'h12345678; model_mem[9'h020] = 32'h12345678;

    rst = 1'b1; cpu_lock = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 9'h0; cpu_wdata = 32'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 9'h0; dbg_wdata = 32'h0;
    cycle(); cycle();
    chk_zero("reset");
    rst = 1'b0;
    cycle();

    // CPU read alone
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
    cycle();
    chk1("t1_cpu_gnt", cpu_gnt, 1'b1);
    chk1("t1_mem_en", mem_en, 1'b1);
    chk32("t1_mem_addr", {23'h0, mem_addr}, 32'h005);
    cycle();
    chk1("t1_cpu_done", cpu_done, 1'b1);
    chk32("t1_rdata", cpu_rdata, 32'h8C010004);
    cycle();
    chk1("t1_done_low", cpu_done, 1'b0);
    chk32("t1_rdata_held", cpu_rdata, 32'h8C010004);
    cycle();

    // Debug write then read
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h1FF; dbg_wdata = 32'hDEADBEEF;
    cycle();
    chk1("t2_dbg_gnt_w", dbg_gnt, 1'b1);
    chk1("t2_mem_we_w", mem_we, 1'b1);
    chk1("t2_owner_w", owner, 1'b1);
    cycle();
    chk1("t2_dbg_done_w", dbg_done, 1'b1);
    cycle();
    cycle();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_wdata = 32'h0;
    cycle();
    chk1("t2_dbg_gnt_r", dbg_gnt, 1'b1);
    chk1("t2_mem_we_r", mem_we, 1'b0);
    cycle();
    chk1("t2_dbg_done_r", dbg_done, 1'b1);
    chk32("t2_dbg_rdata", dbg_rdata, 32'hDEADBEEF);
    chk32("t2_cpu_rdata_kept", cpu_rdata, 32'h8C010004);
    cycle();
    cycle();

    // Contention: both rise together
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h020;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h1FF;
    cycle();
    chk1("t3_cpu_first", cpu_gnt, 1'b1);
    chk1("t3_dbg_not_yet", dbg_gnt, 1'b0);
    chk1("t3_owner0", owner, 1'b0);
    cycle();
    chk1("t3_cpu_done", cpu_done, 1'b1);
    chk32("t3_cpu_rdata", cpu_rdata, 32'h12345678);
    cycle();
    chk1("t3_dbg_gnt", dbg_gnt, 1'b1);
    chk1("t3_owner1", owner, 1'b1);
    cycle();
    chk1("t3_dbg_done", dbg_done, 1'b1);
    cycle();
    cycle();

    // Lock rising during a debug access does not abort it
    dbg_req = 1'b1; dbg_addr = 9'h005;
    cycle();
    chk1("t3b_dbg_gnt", dbg_gnt, 1'b1);
    cpu_lock = 1'b1;
    cycle();
    chk1("t3b_dbg_done", dbg_done, 1'b1);
    chk32("t3b_dbg_rdata", dbg_rdata, 32'h8C010004);
    cpu_lock = 1'b0;
    cycle();
    cycle();

    // Lock and starvation, from a fresh reset
    rst = 1'b1;
    cycle();
    chk_zero("rst2");
    rst = 1'b0;
    cpu_lock = 1'b1; cpu_auto = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h020;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h005;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 7) chk1("t4_starve_before", dbg_starve, 1'b0);
      if (k == 8) chk1("t4_starve_set", dbg_starve, 1'b1);
      if (dbg_gnt === 1'b1) seen++;
      cycle();
    end
    chk32("t4_no_dbg_gnt", seen, 0);
    chk1("t4_starve_held", dbg_starve, 1'b1);
    cpu_lock = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      cycle();
      if (dbg_gnt === 1'b1) begin
        got = 1'b1;
        chk1("t4_starve_clr", dbg_starve, 1'b0);
      end
    end
    if (!got) begin
      failures++;
      $display("FAIL t4_dbg_gnt_timeout: got no dbg_gnt want one within 12 cycles");
    end
    checks++;
    cpu_auto = 1'b0;
    repeat (10) cycle();
    chk32("t4_dbg_rdata", dbg_rdata, 32'h8C010004);
    chk32("t4_cpu_rdata", cpu_rdata, 32'h12345678);

    // Reset during CPU ISSUE
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
    cycle();
    chk1("t5_cpu_gnt", cpu_gnt, 1'b1);
    rst = 1'b1; cpu_req = 1'b0;
    cycle();
    chk_zero("t5_rst");
    rst = 1'b0;
    cycle();
    chk1("t5_no_done", cpu_done, 1'b0);
    cpu_req = 1'b1; cpu_addr = 9'h1FF;
    cycle();
    chk1("t5_fresh_gnt", cpu_gnt, 1'b1);
    cycle();
    chk1("t5_fresh_done", cpu_done, 1'b1);
    chk32("t5_fresh_rdata", cpu_rdata, 32'hDEADBEEF);
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
